// File: rtl/r4_pkg.sv
// rtl/r4_pkg.sv - shared types and control-line mapping for the radix-4 butterfly driver
package r4_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } cplx_t;

    // Control word bit positions: C_EN is c1, C_IDX is {c3,c2}
    localparam int C_EN     = 0;
    localparam int C_IDX_LO = 1;
    localparam int C_IDX_HI = 2;

    function automatic logic [2:0] ctrl_word(input logic en, input logic [1:0] k);
        logic [2:0] w;
        w                   = '0;
        w[C_EN]             = en;
        w[C_IDX_HI:C_IDX_LO] = k;
        return w;
    endfunction

endpackage

// File: rtl/r4_butter_driver_if.sv
// rtl/r4_butter_driver_if.sv - input sample stream and output result stream of the driver
interface r4_butter_driver_if;

    logic                 in_valid;
    logic                 in_ready;
    logic [r4_pkg::W-1:0] in_re;
    logic [r4_pkg::W-1:0] in_im;

    logic                 out_valid;
    logic                 out_ready;
    logic [r4_pkg::W-1:0] out_re;
    logic [r4_pkg::W-1:0] out_im;
    logic [1:0]           out_idx;
    logic                 out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

endinterface

// File: rtl/r4_capture_pipe.sv
// rtl/r4_capture_pipe.sv - delays {valid,k} tags by BFLY_LAT and captures Xro/Xio into res[k]
module r4_capture_pipe
    import r4_pkg::*;
#(
    parameter int BFLY_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      ctrl,
    input  cplx_t           res_in,
    output cplx_t [3:0]     res,
    output logic            done
);

    // tag = {valid, k}, aligned with the butterfly result it describes
    logic [2:0] tag;

    generate
        if (BFLY_LAT == 0) begin : g_lat0
            assign tag = {ctrl[C_EN], ctrl[C_IDX_HI:C_IDX_LO]};
        end else begin : g_shift
            logic [BFLY_LAT-1:0][2:0] sh;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    sh <= '0;
                end else begin
                    sh[0] <= {ctrl[C_EN], ctrl[C_IDX_HI:C_IDX_LO]};
                    for (int i = 1; i < BFLY_LAT; i++) begin
                        sh[i] <= sh[i-1];
                    end
                end
            end

            assign tag = sh[BFLY_LAT-1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tag[2]) begin
                res[tag[1:0]] <= res_in;
                done          <= (tag[1:0] == 2'd3);
            end
        end
    end

endmodule

// File: rtl/r4_butter_driver.sv
// rtl/r4_butter_driver.sv - buffers a 4-point frame, sequences the butterfly bins and streams the results
module r4_butter_driver
    import r4_pkg::*;
#(
    parameter int BFLY_LAT = 1
) (
    input  logic         CLK,
    input  logic         RST,
    r4_butter_driver_if.slave bus,
    output logic [W-1:0] xr0,
    output logic [W-1:0] xr1,
    output logic [W-1:0] xr2,
    output logic [W-1:0] xr3,
    output logic [W-1:0] xi0,
    output logic [W-1:0] xi1,
    output logic [W-1:0] xi2,
    output logic [W-1:0] xi3,
    output logic         c1,
    output logic         c2,
    output logic         c3,
    input  logic [W-1:0] Xro,
    input  logic [W-1:0] Xio,
    output logic         busy
);

    state_t      state;
    logic [1:0]  fill_cnt;
    logic [1:0]  k;
    logic [1:0]  j;
    logic [1:0]  j_next;
    cplx_t [3:0] opnd;
    cplx_t [3:0] res;
    logic [2:0]  ctrl;
    logic        done;

    assign xr0 = opnd[0].re;
    assign xr1 = opnd[1].re;
    assign xr2 = opnd[2].re;
    assign xr3 = opnd[3].re;
    assign xi0 = opnd[0].im;
    assign xi1 = opnd[1].im;
    assign xi2 = opnd[2].im;
    assign xi3 = opnd[3].im;

    assign c1 = ctrl[C_EN];
    assign c2 = ctrl[C_IDX_LO];
    assign c3 = ctrl[C_IDX_HI];

    assign j_next = j + 2'd1;

    r4_capture_pipe #(
        .BFLY_LAT (BFLY_LAT)
    ) u_capture (
        .CLK    (CLK),
        .RST    (RST),
        .ctrl   (ctrl),
        .res_in ({Xro, Xio}),
        .res    (res),
        .done   (done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= FILL;
            fill_cnt      <= 2'd0;
            k             <= 2'd0;
            j             <= 2'd0;
            opnd          <= '0;
            ctrl          <= '0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_idx   <= 2'd0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        opnd[fill_cnt] <= {bus.in_re, bus.in_im};
                        fill_cnt       <= fill_cnt + 2'd1;
                        if (fill_cnt == 2'd3) begin
                            state        <= ISSUE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b1;
                            k            <= 2'd0;
                            ctrl         <= ctrl_word(1'b1, 2'd0);
                        end
                    end
                end

                ISSUE: begin
                    if (k == 2'd3) begin
                        ctrl  <= ctrl_word(1'b0, 2'd0);
                        state <= DRAIN;
                    end else begin
                        k    <= k + 2'd1;
                        ctrl <= ctrl_word(1'b1, k + 2'd1);
                    end
                end

                // Leave only once the bin-3 capture has landed in the result file
                DRAIN: begin
                    if (done) begin
                        state         <= OUT;
                        j             <= 2'd0;
                        bus.out_valid <= 1'b1;
                        bus.out_re    <= res[0].re;
                        bus.out_im    <= res[0].im;
                        bus.out_idx   <= 2'd0;
                        bus.out_last  <= 1'b0;
                    end
                end

                OUT: begin
                    if (bus.out_ready) begin
                        if (j == 2'd3) begin
                            state         <= FILL;
                            fill_cnt      <= 2'd0;
                            busy          <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.out_re    <= '0;
                            bus.out_im    <= '0;
                            bus.out_idx   <= 2'd0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            j            <= j_next;
                            bus.out_re   <= res[j_next].re;
                            bus.out_im   <= res[j_next].im;
                            bus.out_idx  <= j_next;
                            bus.out_last <= (j_next == 2'd3);
                        end
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_r4_butter_driver.sv
// tb/tb_r4_butter_driver.sv - scoreboard bench for r4_butter_driver at BFLY_LAT 0, 1 and 3
module tb_r4_butter_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic [3:0] in_re = 4'd0;
    logic [3:0] in_im = 4'd0;
    logic       out_ready = 1'b0;
    int         sel = 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bfly(input logic [15:0] rv, input logic [15:0] iv, input logic [1:0] k);
        int sr, si, a, b, m;
        sr = 0;
        si = 0;
        for (int n = 0; n < 4; n++) begin
            a = int'(rv[n*4 +: 4]);
            b = int'(iv[n*4 +: 4]);
            m = (n * int'(k)) % 4;
            case (m)
                0: begin sr += a; si += b; end
                1: begin sr += b; si -= a; end
                2: begin sr -= a; si -= b; end
                default: begin sr -= b; si += a; end
            endcase
        end
        return {sr[3:0], si[3:0]};
    endfunction

    r4_butter_driver_if b0();
    r4_butter_driver_if b1();
    r4_butter_driver_if b3();

    assign b0.in_valid = in_valid && (sel == 0);
    assign b1.in_valid = in_valid && (sel == 1);
    assign b3.in_valid = in_valid && (sel == 3);
    assign b0.in_re = in_re;  assign b0.in_im = in_im;
    assign b1.in_re = in_re;  assign b1.in_im = in_im;
    assign b3.in_re = in_re;  assign b3.in_im = in_im;
    assign b0.out_ready = out_ready && (sel == 0);
    assign b1.out_ready = out_ready && (sel == 1);
    assign b3.out_ready = out_ready && (sel == 3);

    wire [15:0] xr_v0, xi_v0, xr_v1, xi_v1, xr_v3, xi_v3;
    wire        c1_0, c2_0, c3_0, busy_0;
    wire        c1_1, c2_1, c3_1, busy_1;
    wire        c1_3, c2_3, c3_3, busy_3;
    wire [3:0]  xro0, xio0, xro1, xio1, xro3, xio3;

    // Behavioural butterfly models, delayed to each instance's latency
    wire [7:0]  bf0 = bfly(xr_v0, xi_v0, {c3_0, c2_0});
    wire [7:0]  bf1 = bfly(xr_v1, xi_v1, {c3_1, c2_1});
    wire [7:0]  bf3 = bfly(xr_v3, xi_v3, {c3_3, c2_3});
    logic [7:0] d1 = 8'd0;
    logic [7:0] d3 [3];

    always @(posedge clk) begin
        d1    <= bf1;
        d3[0] <= bf3;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end

    assign {xro0, xio0} = bf0;
    assign {xro1, xio1} = d1;
    assign {xro3, xio3} = d3[2];

    r4_butter_driver #(.BFLY_LAT(0)) dut0 (
        .CLK(clk), .RST(rst_n), .bus(b0.slave),
        .xr0(xr_v0[3:0]), .xr1(xr_v0[7:4]), .xr2(xr_v0[11:8]), .xr3(xr_v0[15:12]),
        .xi0(xi_v0[3:0]), .xi1(xi_v0[7:4]), .xi2(xi_v0[11:8]), .xi3(xi_v0[15:12]),
        .c1(c1_0), .c2(c2_0), .c3(c3_0), .Xro(xro0), .Xio(xio0), .busy(busy_0)
    );

    r4_butter_driver #(.BFLY_LAT(1)) dut1 (
        .CLK(clk), .RST(rst_n), .bus(b1.slave),
        .xr0(xr_v1[3:0]), .xr1(xr_v1[7:4]), .xr2(xr_v1[11:8]), .xr3(xr_v1[15:12]),
        .xi0(xi_v1[3:0]), .xi1(xi_v1[7:4]), .xi2(xi_v1[11:8]), .xi3(xi_v1[15:12]),
        .c1(c1_1), .c2(c2_1), .c3(c3_1), .Xro(xro1), .Xio(xio1), .busy(busy_1)
    );

    r4_butter_driver #(.BFLY_LAT(3)) dut3 (
        .CLK(clk), .RST(rst_n), .bus(b3.slave),
        .xr0(xr_v3[3:0]), .xr1(xr_v3[7:4]), .xr2(xr_v3[11:8]), .xr3(xr_v3[15:12]),
        .xi0(xi_v3[3:0]), .xi1(xi_v3[7:4]), .xi2(xi_v3[11:8]), .xi3(xi_v3[15:12]),
        .c1(c1_3), .c2(c2_3), .c3(c3_3), .Xro(xro3), .Xio(xio3), .busy(busy_3)
    );

    logic        m_valid, m_last, m_c1, m_busy, m_inrdy;
    logic [1:0]  m_idx, m_cidx;
    logic [3:0]  m_re, m_im;
    logic [15:0] m_xr;

    always_comb begin
        case (sel)
            0: begin
                m_valid = b0.out_valid; m_last = b0.out_last; m_idx = b0.out_idx;
                m_re = b0.out_re; m_im = b0.out_im; m_inrdy = b0.in_ready;
                m_c1 = c1_0; m_cidx = {c3_0, c2_0}; m_busy = busy_0; m_xr = xr_v0 | xi_v0;
            end
            1: begin
                m_valid = b1.out_valid; m_last = b1.out_last; m_idx = b1.out_idx;
                m_re = b1.out_re; m_im = b1.out_im; m_inrdy = b1.in_ready;
                m_c1 = c1_1; m_cidx = {c3_1, c2_1}; m_busy = busy_1; m_xr = xr_v1 | xi_v1;
            end
            default: begin
                m_valid = b3.out_valid; m_last = b3.out_last; m_idx = b3.out_idx;
                m_re = b3.out_re; m_im = b3.out_im; m_inrdy = b3.in_ready;
                m_c1 = c1_3; m_cidx = {c3_3, c2_3}; m_busy = busy_3; m_xr = xr_v3 | xi_v3;
            end
        endcase
    end

    logic [10:0] exp_q[$];
    logic [3:0]  smp_re [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hC, 4'h2};
    logic [3:0]  smp_im [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    logic [15:0] fr_re, fr_im;
    int          fc = 0;

    task automatic send(input int first, input int count, input int budget);
        int i, cyc;
        i   = first;
        cyc = 0;
        while (i < first + count && cyc < budget) begin
            @(negedge clk);
            #1;
            in_valid = 1'b1;
            in_re    = smp_re[i];
            in_im    = smp_im[i];
            if (m_inrdy) begin
                fr_re[fc*4 +: 4] = smp_re[i];
                fr_im[fc*4 +: 4] = smp_im[i];
                fc++;
                if (fc == 4) begin
                    for (int k = 0; k < 4; k++)
                        exp_q.push_back({2'(k), (k == 3), bfly(fr_re, fr_im, 2'(k))});
                    fc = 0;
                end
                i++;
            end
            cyc++;
        end
        @(negedge clk);
        #1 in_valid = 1'b0;
        if (i < first + count) chk("in_timeout", i, first + count);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || m_busy) && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (c >= 300) chk("out_timeout", exp_q.size(), 0);
    endtask

    int          pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int          pi = 0;
    bit          use_pat = 1'b0;
    int          c1_cnt = 0;
    int          drain = 0;
    bit          held = 1'b0;
    logic [10:0] snap, cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            c1_cnt = 0;
            drain  = 0;
            held   = 1'b0;
        end else begin
            cur = {m_idx, m_last, m_re, m_im};
            if (m_c1) begin
                chk("ctl_idx", m_cidx, c1_cnt[1:0]);
                c1_cnt++;
            end else if (c1_cnt != 0) begin
                chk("ctl_len", c1_cnt, 4);
                c1_cnt = 0;
            end
            if (m_busy && !m_c1 && !m_valid) begin
                drain++;
            end else if (drain != 0) begin
                chk("drain_len", drain, sel + 1);
                drain = 0;
            end
            if (m_valid) begin
                if (held) chk("hold", cur, snap);
                if (use_pat && pi < 7) begin
                    out_ready = pat[pi][0];
                    pi++;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) chk("extra_beat", cur, 11'h0);
                    else chk("beat", cur, exp_q.pop_front());
                end else begin
                    held = 1'b1;
                    snap = cur;
                end
            end else begin
                out_ready = 1'b0;
                held      = 1'b0;
            end
        end
    end

    initial begin
        sel   = 1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", m_inrdy, 0);
        chk("rst_out_valid", m_valid, 0);
        chk("rst_c1", m_c1, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_operands", m_xr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", m_inrdy, 1);

        send(0, 4, 50);
        wait_idle();

        use_pat = 1'b1;
        pi      = 0;
        send(0, 4, 50);
        wait_idle();
        use_pat = 1'b0;

        send(0, 8, 200);
        wait_idle();

        sel = 0;
        send(4, 4, 50);
        wait_idle();
        sel = 3;
        send(0, 4, 50);
        wait_idle();

        sel = 1;
        send(4, 4, 50);
        for (int c = 0; c < 20 && !(m_c1 && m_cidx == 2'd2); c++) @(negedge clk);
        chk("reached_k2", {m_c1, m_cidx}, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_c1", {m_c1, m_cidx}, 0);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_in_ready", m_inrdy, 0);
        chk("mid_rst_out", {m_valid, m_idx, m_last, m_re, m_im}, 0);
        chk("mid_rst_operands", m_xr, 0);
        exp_q.delete();
        fc = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(0, 4, 50);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
